// File: rtl/mem_level_pkg.sv
// Shared definitions for the MEM stage: instruction ids, field widths and
// the instruction-class decode used to tell loads and stores apart.
package mem_level_pkg;

    localparam int WIDTH_INSTR = 6;
    localparam int WIDTH_T     = 2;
    localparam int WIDTH_FUNC  = 2;

    localparam logic [WIDTH_INSTR-1:0] I_NOP  = 6'd0;
    localparam logic [WIDTH_INSTR-1:0] I_ADDU = 6'd1;
    localparam logic [WIDTH_INSTR-1:0] I_SUBU = 6'd2;
    localparam logic [WIDTH_INSTR-1:0] I_ORI  = 6'd3;
    localparam logic [WIDTH_INSTR-1:0] I_LW   = 6'd4;
    localparam logic [WIDTH_INSTR-1:0] I_LH   = 6'd5;
    localparam logic [WIDTH_INSTR-1:0] I_LHU  = 6'd6;
    localparam logic [WIDTH_INSTR-1:0] I_LB   = 6'd7;
    localparam logic [WIDTH_INSTR-1:0] I_LBU  = 6'd8;
    localparam logic [WIDTH_INSTR-1:0] I_SW   = 6'd9;
    localparam logic [WIDTH_INSTR-1:0] I_SH   = 6'd10;
    localparam logic [WIDTH_INSTR-1:0] I_SB   = 6'd11;

    typedef enum logic [WIDTH_FUNC-1:0] {
        FUNC_ALU       = 2'd0,
        FUNC_MEM_READ  = 2'd1,
        FUNC_MEM_WRITE = 2'd2
    } func_t;

    function automatic func_t ic(input logic [WIDTH_INSTR-1:0] instr);
        func_t f;
        case (instr)
            I_LW, I_LH, I_LHU, I_LB, I_LBU: f = FUNC_MEM_READ;
            I_SW, I_SH, I_SB:               f = FUNC_MEM_WRITE;
            default:                        f = FUNC_ALU;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_level_data_memory.sv
// Word-organised data memory: asynchronous read, byte-enabled synchronous
// write, and a synchronous reset that clears every word.
module data_memory #(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [DM_AW-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DM_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_level.sv
// MEM pipeline stage: store-data forwarding from WB, byte-lane stores and
// extending loads against the data memory, and the MEM/WB registers.
module mem_level
    import mem_level_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   clr,
    input  logic [WIDTH_INSTR-1:0] instr_MEM,
    input  logic [31:0]            PC_MEM,
    input  logic [31:0]            aluOut_MEM,
    input  logic [31:0]            memWriteData_MEM,
    input  logic [4:0]             addrRt_MEM,
    input  logic [4:0]             regWriteAddr_MEM,
    input  logic [31:0]            regWriteData_MEM,
    input  logic [WIDTH_T-1:0]     Tnew_MEM,
    input  logic [4:0]             regaddr_WB,
    input  logic [31:0]            regdata_WB,
    output logic [4:0]             regaddr_MEM,
    output logic [31:0]            regdata_MEM,
    output logic [WIDTH_INSTR-1:0] instr_WB,
    output logic [31:0]            PC_WB,
    output logic [4:0]             regWriteAddr_WB,
    output logic [31:0]            regWriteData_WB,
    output logic [WIDTH_T-1:0]     Tnew_WB
);

    localparam logic [WIDTH_T-1:0] T_ONE = WIDTH_T'(1);

    func_t            func;
    logic [1:0]       lane;
    logic [DM_AW-1:0] idx;
    logic [31:0]      wd;
    logic [31:0]      dm_wdata;
    logic [31:0]      dm_rdata;
    logic [3:0]       be;
    logic             we;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_val;
    logic [31:0]      wb_data;
    logic             unused_addr_bits;

    logic [WIDTH_INSTR-1:0] instr_d, instr_q;
    logic [31:0]            pc_d, pc_q;
    logic [4:0]             rwa_d, rwa_q;
    logic [31:0]            rwd_d, rwd_q;
    logic [WIDTH_T-1:0]     tnew_d, tnew_q;

    // Upper address bits fall outside the memory and simply alias.
    assign unused_addr_bits = ^aluOut_MEM[31:DM_AW+2];
    assign lane = aluOut_MEM[1:0];
    assign idx  = aluOut_MEM[DM_AW+1:2];

    always_comb begin
        func     = ic(instr_MEM);
        wd       = ((regaddr_WB == addrRt_MEM) && (regaddr_WB != 5'd0)) ? regdata_WB
                                                                          : memWriteData_MEM;
        be       = 4'b0000;
        dm_wdata = wd;
        case (instr_MEM)
            I_SW: be = 4'b1111;
            I_SH: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                dm_wdata = {2{wd[15:0]}};
            end
            I_SB: begin
                be       = 4'b0001 << lane;
                dm_wdata = {4{wd[7:0]}};
            end
            default: ;
        endcase
        we = (func == FUNC_MEM_WRITE) && !clr && !stall;
    end

    data_memory #(
        .DM_WORDS (DM_WORDS),
        .DM_AW    (DM_AW)
    ) u_dm (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .be    (be),
        .idx   (idx),
        .wdata (dm_wdata),
        .rdata (dm_rdata)
    );

    always_comb begin
        case (lane)
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (instr_MEM)
            I_LH:    load_val = {{16{ld_half[15]}}, ld_half};
            I_LHU:   load_val = {16'd0, ld_half};
            I_LB:    load_val = {{24{ld_byte[7]}}, ld_byte};
            I_LBU:   load_val = {24'd0, ld_byte};
            default: load_val = dm_rdata;
        endcase
        wb_data = (func == FUNC_MEM_READ) ? load_val : regWriteData_MEM;
    end

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        rwa_d   = rwa_q;
        rwd_d   = rwd_q;
        tnew_d  = tnew_q;
        if (clr) begin
            instr_d = '0;
            pc_d    = '0;
            rwa_d   = '0;
            rwd_d   = '0;
            tnew_d  = '0;
        end else if (!stall) begin
            instr_d = instr_MEM;
            pc_d    = PC_MEM;
            rwa_d   = regWriteAddr_MEM;
            rwd_d   = wb_data;
            tnew_d  = (Tnew_MEM != '0) ? (Tnew_MEM - T_ONE) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            rwa_q   <= '0;
            rwd_q   <= '0;
            tnew_q  <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            rwa_q   <= rwa_d;
            rwd_q   <= rwd_d;
            tnew_q  <= tnew_d;
        end
    end

    assign regaddr_MEM     = (Tnew_MEM == '0) ? regWriteAddr_MEM : 5'd0;
    assign regdata_MEM     = regWriteData_MEM;
    assign instr_WB        = instr_q;
    assign PC_WB           = pc_q;
    assign regWriteAddr_WB = rwa_q;
    assign regWriteData_WB = rwd_q;
    assign Tnew_WB         = tnew_q;

endmodule

// File: tb/tb_mem_level.sv
// Scoreboard bench for mem_level: a byte-array reference model predicts each
// MEM/WB result, and a monitor compares it after every clock edge.
module tb_mem_level;
    import mem_level_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset, stall, clr;
    logic [WIDTH_INSTR-1:0] instr_MEM;
    logic [31:0]            PC_MEM, aluOut_MEM, memWriteData_MEM, regWriteData_MEM, regdata_WB;
    logic [4:0]             addrRt_MEM, regWriteAddr_MEM, regaddr_WB;
    logic [WIDTH_T-1:0]     Tnew_MEM;
    logic [4:0]             regaddr_MEM;
    logic [31:0]            regdata_MEM;
    logic [WIDTH_INSTR-1:0] instr_WB;
    logic [31:0]            PC_WB, regWriteData_WB;
    logic [4:0]             regWriteAddr_WB;
    logic [WIDTH_T-1:0]     Tnew_WB;

    always #5 clk = ~clk;

    mem_level dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .clr              (clr),
        .instr_MEM        (instr_MEM),
        .PC_MEM           (PC_MEM),
        .aluOut_MEM       (aluOut_MEM),
        .memWriteData_MEM (memWriteData_MEM),
        .addrRt_MEM       (addrRt_MEM),
        .regWriteAddr_MEM (regWriteAddr_MEM),
        .regWriteData_MEM (regWriteData_MEM),
        .Tnew_MEM         (Tnew_MEM),
        .regaddr_WB       (regaddr_WB),
        .regdata_WB       (regdata_WB),
        .regaddr_MEM      (regaddr_MEM),
        .regdata_MEM      (regdata_MEM),
        .instr_WB         (instr_WB),
        .PC_WB            (PC_WB),
        .regWriteAddr_WB  (regWriteAddr_WB),
        .regWriteData_WB  (regWriteData_WB),
        .Tnew_WB          (Tnew_WB)
    );

    typedef struct {
        logic [WIDTH_INSTR-1:0] instr;
        logic [31:0]            pc;
        logic [4:0]             rwa;
        logic [31:0]            rwd;
        logic [WIDTH_T-1:0]     tnew;
    } wb_t;

    wb_t        exp_q[$];
    wb_t        last_exp = '{default: '0};
    logic [7:0] mdl [0:4095];
    int         total = 0;
    int         bad = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_load(input logic [WIDTH_INSTR-1:0] i);
        return i inside {I_LW, I_LH, I_LHU, I_LB, I_LBU};
    endfunction

    function automatic bit is_store(input logic [WIDTH_INSTR-1:0] i);
        return i inside {I_SW, I_SH, I_SB};
    endfunction

    // The model sees memory as 4096 bytes, little-endian, addresses modulo size.
    function automatic logic [31:0] mdl_load(input logic [WIDTH_INSTR-1:0] i, input logic [31:0] addr);
        int          a;
        int          w;
        int          h;
        logic [15:0] hv;
        logic [7:0]  bv;
        a  = int'(addr % 32'd4096);
        w  = a - (a % 4);
        h  = a - (a % 2);
        hv = {mdl[h+1], mdl[h]};
        bv = mdl[a];
        if (i == I_LW)       return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
        else if (i == I_LH)  return {{16{hv[15]}}, hv};
        else if (i == I_LHU) return {16'd0, hv};
        else if (i == I_LB)  return {{24{bv[7]}}, bv};
        else                 return {24'd0, bv};
    endfunction

    task automatic mdl_store(input logic [WIDTH_INSTR-1:0] i, input logic [31:0] addr, input logic [31:0] d);
        int a;
        int w;
        int h;
        a = int'(addr % 32'd4096);
        w = a - (a % 4);
        h = a - (a % 2);
        if (i == I_SW) begin
            for (int k = 0; k < 4; k++) mdl[w+k] = d[8*k +: 8];
        end else if (i == I_SH) begin
            mdl[h]   = d[7:0];
            mdl[h+1] = d[15:8];
        end else begin
            mdl[a] = d[7:0];
        end
    endtask

    task automatic setup(input logic [WIDTH_INSTR-1:0] i, input logic [31:0] addr, input logic [31:0] data,
                         input logic st, input logic cl, input logic rs,
                         input logic [4:0] rt, input logic [4:0] wba, input logic [31:0] wbd,
                         input logic [WIDTH_T-1:0] tnew, input logic [4:0] rwa);
        instr_MEM        = i;
        aluOut_MEM       = addr;
        memWriteData_MEM = data;
        stall            = st;
        clr              = cl;
        reset            = rs;
        addrRt_MEM       = rt;
        regaddr_WB       = wba;
        regdata_WB       = wbd;
        Tnew_MEM         = tnew;
        regWriteAddr_MEM = rwa;
        PC_MEM           = $urandom;
        regWriteData_MEM = $urandom;
    endtask

    // Inputs are set just after a falling edge; predict the next rising edge.
    task automatic cycle();
        wb_t         e;
        logic [31:0] sd;
        int          t;
        #1;
        chk32("fwd_addr", {27'd0, regaddr_MEM}, {27'd0, (Tnew_MEM == '0) ? regWriteAddr_MEM : 5'd0});
        chk32("fwd_data", regdata_MEM, regWriteData_MEM);
        if (reset || clr) begin
            e = '{default: '0};
        end else if (stall) begin
            e = last_exp;
        end else begin
            t       = int'(Tnew_MEM);
            e.instr = instr_MEM;
            e.pc    = PC_MEM;
            e.rwa   = regWriteAddr_MEM;
            e.rwd   = is_load(instr_MEM) ? mdl_load(instr_MEM, aluOut_MEM) : regWriteData_MEM;
            e.tnew  = (t == 0) ? '0 : WIDTH_T'(t - 1);
        end
        if (reset) begin
            for (int k = 0; k < 4096; k++) mdl[k] = 8'd0;
        end else if (!clr && !stall && is_store(instr_MEM)) begin
            sd = (regaddr_WB != 5'd0 && regaddr_WB == addrRt_MEM) ? regdata_WB : memWriteData_MEM;
            mdl_store(instr_MEM, aluOut_MEM, sd);
        end
        last_exp = e;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic op(input logic [WIDTH_INSTR-1:0] i, input logic [31:0] addr, input logic [31:0] data,
                      input logic st, input logic cl, input logic rs,
                      input logic [4:0] rt, input logic [4:0] wba, input logic [31:0] wbd,
                      input logic [WIDTH_T-1:0] tnew, input logic [4:0] rwa);
        setup(i, addr, data, st, cl, rs, rt, wba, wbd, tnew, rwa);
        cycle();
    endtask

    task automatic simple(input logic [WIDTH_INSTR-1:0] i, input logic [31:0] addr, input logic [31:0] data);
        op(i, addr, data, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, '0, 5'd9);
    endtask

    initial begin : monitor
        wb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk32("wb_instr", 32'(instr_WB), 32'(e.instr));
                chk32("wb_pc", PC_WB, e.pc);
                chk32("wb_rwa", 32'(regWriteAddr_WB), 32'(e.rwa));
                chk32("wb_rwd", regWriteData_WB, e.rwd);
                chk32("wb_tnew", 32'(Tnew_WB), 32'(e.tnew));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    logic [WIDTH_INSTR-1:0] ops [12];

    initial begin : driver
        ops = '{I_NOP, I_ADDU, I_SUBU, I_ORI, I_LW, I_LH, I_LHU, I_LB, I_LBU, I_SW, I_SH, I_SB};
        for (int k = 0; k < 4096; k++) mdl[k] = 8'd0;
        setup(I_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, '0, 5'd0);
        @(negedge clk);

        op(I_NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, '0, 5'd0);
        chk32("rst_rwd", regWriteData_WB, 32'd0);
        chk32("rst_pc", PC_WB, 32'd0);

        simple(I_SW, 32'h10, 32'h12345678);
        simple(I_LW, 32'h10, 32'd0);
        chk32("lw", regWriteData_WB, 32'h12345678);
        simple(I_LB, 32'h13, 32'd0);
        chk32("lb", regWriteData_WB, 32'h00000012);
        simple(I_LBU, 32'h11, 32'd0);
        chk32("lbu", regWriteData_WB, 32'h00000056);

        simple(I_SH, 32'h22, 32'h00008001);
        simple(I_LW, 32'h20, 32'd0);
        chk32("sh_word", regWriteData_WB, 32'h80010000);
        simple(I_LH, 32'h22, 32'd0);
        chk32("lh", regWriteData_WB, 32'hFFFF8001);
        simple(I_LHU, 32'h22, 32'd0);
        chk32("lhu", regWriteData_WB, 32'h00008001);

        simple(I_SW, 32'h30, 32'hFFFFFFFF);
        op(I_SB, 32'h30, 32'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 32'h000000AB, '0, 5'd9);
        op(I_SB, 32'h31, 32'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 32'h000000AB, '0, 5'd9);
        simple(I_LW, 32'h30, 32'd0);
        chk32("sb_fwd", regWriteData_WB, 32'hFFFF00AB);

        simple(I_ADDU, 32'h0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            op(I_SW, 32'h40, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, '0, 5'd9);
            chk32("stall_hold", 32'(instr_WB), 32'(I_ADDU));
        end
        simple(I_SW, 32'h40, 32'hCAFEF00D);
        simple(I_LW, 32'h40, 32'd0);
        chk32("stall_write", regWriteData_WB, 32'hCAFEF00D);

        op(I_SW, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 2'd2, 5'd9);
        chk32("clr_instr", 32'(instr_WB), 32'd0);
        chk32("clr_rwd", regWriteData_WB, 32'd0);
        chk32("clr_tnew", 32'(Tnew_WB), 32'd0);
        simple(I_LW, 32'h40, 32'd0);
        chk32("clr_nowrite", regWriteData_WB, 32'hCAFEF00D);

        setup(I_ADDU, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 2'd0, 5'd8);
        #1 chk32("fwd_t0", 32'(regaddr_MEM), 32'd8);
        cycle();
        setup(I_LW, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 2'd1, 5'd8);
        #1 chk32("fwd_t1", 32'(regaddr_MEM), 32'd0);
        cycle();
        chk32("tnew_dec", 32'(Tnew_WB), 32'd0);

        simple(I_SW, 32'h1010, 32'h5A5A5A5A);
        simple(I_LW, 32'h10, 32'd0);
        chk32("alias", regWriteData_WB, 32'h5A5A5A5A);

        op(I_SW, 32'h50, 32'h77777777, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, '0, 5'd9);
        simple(I_LW, 32'h50, 32'd0);
        chk32("rst_store", regWriteData_WB, 32'd0);

        for (int n = 0; n < 500; n++) begin
            logic [31:0] addr;
            addr = {20'd0, 12'($urandom_range(0, 127))};
            if ($urandom_range(0, 3) == 0) addr[31:12] = 20'($urandom);
            op(ops[$urandom_range(0, 11)], addr, $urandom,
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 149) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom,
               WIDTH_T'($urandom), 5'($urandom));
        end

        simple(I_NOP, 32'd0, 32'd0);
        chk32("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
